// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, TX arbiter state encoding and system clock rate.
package uart_pkg;

   localparam int CLK_FREQ = 50_000_000;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_ACTIVE
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N    = 2,
   parameter int ID_W = id_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic            found,
   output logic [ID_W-1:0] idx
);

   always_comb begin : pick
      int j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      // Walk from farthest to nearest so the nearest set bit overwrites the rest.
      for (int k = N; k >= 1; k--) begin
         j = (int'(last) + k) % N;
         if (req[ID_W'(j)]) begin
            found = 1'b1;
            idx   = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX serializer between NUM_REQ
// byte streams, with a stall timeout that reclaims the path from a silent grantee.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no grant; picks the next valid requester after last_grant
// ARB_ACTIVE | grantee's stream passed straight through to the TX module
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int ID_W           = id_width(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 timeout_pulse
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state, state_nxt;
   logic [ID_W-1:0]  grant, grant_nxt;
   logic [ID_W-1:0]  last_grant, last_grant_nxt;
   logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
   logic             timeout_nxt;

   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   byte_t            req_bytes [NUM_REQ];

   logic             g_valid;
   logic             g_last;
   logic             g_xfer;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_bytes[i] = req_data[8*i +: 8];
   end

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .last  (last_grant),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign g_valid = req_valid[grant];
   assign g_last  = req_last[grant];
   assign g_xfer  = g_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         grant         <= '0;
         last_grant    <= ID_W'(NUM_REQ - 1);
         stall_cnt     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         last_grant    <= last_grant_nxt;
         stall_cnt     <= stall_cnt_nxt;
         timeout_pulse <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      stall_cnt_nxt  = stall_cnt;
      timeout_nxt    = 1'b0;
      tx_data        = '0;
      tx_valid       = 1'b0;
      req_ready      = '0;
      busy           = 1'b0;
      grant_id       = '0;

      case (state)
         ARB_IDLE: begin
            stall_cnt_nxt = '0;
            if (pick_found) begin
               grant_nxt = pick_idx;
               state_nxt = ARB_ACTIVE;
            end
         end

         ARB_ACTIVE: begin
            tx_data          = req_bytes[grant];
            tx_valid         = g_valid;
            req_ready[grant] = tx_ready;
            busy             = 1'b1;
            grant_id         = grant;

            if (g_xfer) begin
               stall_cnt_nxt = '0;
               if (g_last) begin
                  state_nxt      = ARB_IDLE;
                  last_grant_nxt = grant;
               end
            end else if (!g_valid) begin
               // Valid-but-not-ready is TX backpressure, not a stall, so only !valid counts.
               if (stall_cnt == CNT_LAST) begin
                  state_nxt      = ARB_IDLE;
                  last_grant_nxt = grant;
                  stall_cnt_nxt  = '0;
                  timeout_nxt    = 1'b1;
               end else begin
                  stall_cnt_nxt = stall_cnt + 1'b1;
               end
            end
         end

         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule
